sd_sector_loader: RTL and testbench

Multi-block loader sitting directly downstream of `sd_card_manager`. It turns a "load N sectors starting at block B" request into a sequence of single-block reads. Each returned byte stream is written into cartridge ROM memory (BSRAM/PSRAM write port) at consecutive addresses. It counts bytes per sector, retries failed or short sectors, and reports completion or a coded error to the cart control logic.

---
 rtl/sd_pkg.sv | 21 ++
 rtl/sd_loader_watchdog.sv | 28 ++
 rtl/sd_sector_loader.sv | 209 ++++++++++++++++++++
 tb/tb_sd_sector_loader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD sector loader and its watchdog.
package sd_pkg;

  localparam int unsigned SECTOR_BYTES_DEFAULT = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_COLLECT,
    ST_ADVANCE,
    ST_FINISH,
    ST_FAIL
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_NOINIT   = 2'd1;
  localparam logic [1:0] ERR_RETRY    = 2'd2;
  localparam logic [1:0] ERR_CAPACITY = 2'd3;

endpackage

// File: rtl/sd_loader_watchdog.sv
// Per-sector read watchdog: reloads on clear, counts down while enabled, flags expiry at zero.
module sd_loader_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= W'(TIMEOUT_CYCLES);
    end else if (clear) begin
      count_reg <= W'(TIMEOUT_CYCLES);
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/sd_sector_loader.sv
// Multi-sector SD loader writing sector data into cartridge ROM with per-sector retry.
// Optional running byte checksum output enabled by defining SD_LOADER_CHECKSUM_EN.
module sd_sector_loader
  import sd_pkg::*;
#(
  parameter int          ADDR_W         = 17,
  parameter int unsigned SECTOR_BYTES   = SECTOR_BYTES_DEFAULT,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       base_block,
  input  logic [15:0]       num_blocks,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [15:0]       blocks_loaded,
  input  logic              sd_init_done,
  output logic              sd_start_read,
  output logic [31:0]       sd_block_addr,
  input  logic [7:0]        sd_read_data,
  input  logic              sd_read_data_valid,
  input  logic              sd_read_done,
  input  logic              sd_error,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata
`ifdef SD_LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int BCNT_W = $clog2(SECTOR_BYTES) + 1;

  state_t            state_reg;
  logic [31:0]       base_reg;
  logic [15:0]       num_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [BCNT_W-1:0] byte_cnt_reg;
  logic              overrun_reg;
  logic [7:0]        retry_reg;
`ifdef SD_LOADER_CHECKSUM_EN
  logic [15:0]       checksum_saved_reg;
`endif

  logic              wd_expired;
  logic              byte_accept;
  logic [BCNT_W-1:0] byte_cnt_next;
  logic              overrun_next;
  logic              sector_ok;
  logic              sector_bad;
  logic [31:0]       cap_bytes;
  logic [31:0]       cap_limit;
  logic [ADDR_W-1:0] sector_base;
  logic [7:0]        retry_next;
  logic              last_block;

  sd_loader_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_reg == ST_ISSUE),
    .enable (state_reg == ST_COLLECT),
    .expired(wd_expired)
  );

  // A byte arriving together with sd_read_done is counted before completion is judged.
  assign byte_accept   = sd_read_data_valid && (byte_cnt_reg < BCNT_W'(SECTOR_BYTES));
  assign byte_cnt_next = byte_cnt_reg + BCNT_W'(byte_accept);
  assign overrun_next  = overrun_reg | (sd_read_data_valid && !byte_accept);
  assign sector_ok     = sd_read_done && (byte_cnt_next == BCNT_W'(SECTOR_BYTES))
                         && !overrun_next && !sd_error;
  assign sector_bad    = sd_error || wd_expired || (sd_read_done && !sector_ok);

  assign cap_bytes   = 32'(num_reg) * 32'(SECTOR_BYTES);
  assign cap_limit   = 32'(1) << ADDR_W;
  assign sector_base = ADDR_W'(32'(blocks_loaded) * 32'(SECTOR_BYTES));
  assign retry_next  = retry_reg + 8'd1;
  assign last_block  = (blocks_loaded + 16'd1) == num_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= ST_IDLE;
      base_reg           <= '0;
      num_reg            <= '0;
      wr_addr_reg        <= '0;
      byte_cnt_reg       <= '0;
      overrun_reg        <= 1'b0;
      retry_reg          <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      err_code           <= ERR_NONE;
      blocks_loaded      <= '0;
      sd_start_read      <= 1'b0;
      sd_block_addr      <= '0;
      mem_we             <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= '0;
`ifdef SD_LOADER_CHECKSUM_EN
      checksum           <= '0;
      checksum_saved_reg <= '0;
`endif
    end else begin
      done          <= 1'b0;
      error         <= 1'b0;
      sd_start_read <= 1'b0;
      mem_we        <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            base_reg      <= base_block;
            num_reg       <= num_blocks;
            blocks_loaded <= '0;
            err_code      <= ERR_NONE;
            wr_addr_reg   <= '0;
            retry_reg     <= '0;
            busy          <= 1'b1;
`ifdef SD_LOADER_CHECKSUM_EN
            checksum           <= '0;
            checksum_saved_reg <= '0;
`endif
            state_reg     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!sd_init_done) begin
            err_code  <= ERR_NOINIT;
            error     <= 1'b1;
            busy      <= 1'b0;
            state_reg <= ST_FAIL;
          end else if (cap_bytes > cap_limit) begin
            err_code  <= ERR_CAPACITY;
            error     <= 1'b1;
            busy      <= 1'b0;
            state_reg <= ST_FAIL;
          end else if (num_reg == 16'd0) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= ST_FINISH;
          end else begin
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          sd_block_addr <= base_reg + 32'(blocks_loaded);
          sd_start_read <= 1'b1;
          byte_cnt_reg  <= '0;
          overrun_reg   <= 1'b0;
          state_reg     <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (byte_accept) begin
            mem_we      <= 1'b1;
            mem_addr    <= wr_addr_reg;
            mem_wdata   <= sd_read_data;
            wr_addr_reg <= wr_addr_reg + 1'b1;
`ifdef SD_LOADER_CHECKSUM_EN
            checksum    <= checksum + {8'd0, sd_read_data};
`endif
          end
          byte_cnt_reg <= byte_cnt_next;
          overrun_reg  <= overrun_next;
          if (sector_ok) begin
            state_reg <= ST_ADVANCE;
          end else if (sector_bad) begin
            // Rewind overrides the increment above so the retry rewrites the same sector.
            wr_addr_reg <= sector_base;
            retry_reg   <= retry_next;
`ifdef SD_LOADER_CHECKSUM_EN
            checksum    <= checksum_saved_reg;
`endif
            if (retry_next <= 8'(MAX_RETRY)) begin
              state_reg <= ST_ISSUE;
            end else begin
              err_code  <= ERR_RETRY;
              error     <= 1'b1;
              busy      <= 1'b0;
              state_reg <= ST_FAIL;
            end
          end
        end
        ST_ADVANCE: begin
          blocks_loaded <= blocks_loaded + 16'd1;
          retry_reg     <= '0;
`ifdef SD_LOADER_CHECKSUM_EN
          checksum_saved_reg <= checksum;
`endif
          if (last_block) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= ST_FINISH;
          end else begin
            state_reg <= ST_ISSUE;
          end
        end
        ST_FINISH: state_reg <= ST_IDLE;
        ST_FAIL:   state_reg <= ST_IDLE;
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_loader.sv
// Directed self-checking bench for sd_sector_loader with a byte-stream SD model and ROM shadow.
module tb_sd_sector_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_block;
  logic [15:0] num_blocks;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [15:0] blocks_loaded;
  logic        sd_init_done;
  logic        sd_start_read;
  logic [31:0] sd_block_addr;
  logic [7:0]  sd_read_data;
  logic        sd_read_data_valid;
  logic        sd_read_done;
  logic        sd_error;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
`ifdef SD_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  sd_sector_loader dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_block        (base_block),
    .num_blocks        (num_blocks),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .err_code          (err_code),
    .blocks_loaded     (blocks_loaded),
    .sd_init_done      (sd_init_done),
    .sd_start_read     (sd_start_read),
    .sd_block_addr     (sd_block_addr),
    .sd_read_data      (sd_read_data),
    .sd_read_data_valid(sd_read_data_valid),
    .sd_read_done      (sd_read_done),
    .sd_error          (sd_error),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata)
`ifdef SD_LOADER_CHECKSUM_EN
    ,
    .checksum          (checksum)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Monitor: counts DUT events on the falling edge and shadows ROM writes.
  logic [7:0]  rom [0:131071];
  logic [31:0] blk_addr [0:63];
  int          first_wr [0:63];
  int          sr_total = 0, wr_total = 0, done_total = 0, err_total = 0;
  int          last_wr_addr = 0;
  bit          first_pending = 0;

  always @(negedge clk) begin
    if (sd_start_read) begin
      blk_addr[sr_total % 64] = sd_block_addr;
      first_pending = 1;
      sr_total++;
    end
    if (mem_we) begin
      rom[mem_addr] = mem_wdata;
      if (first_pending) begin
        first_wr[(sr_total - 1) % 64] = int'(mem_addr);
        first_pending = 0;
      end
      last_wr_addr = int'(mem_addr);
      wr_total++;
    end
    if (done)  done_total++;
    if (error) err_total++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    base_block = b;
    num_blocks = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_start(input string tag, output int cycles);
    bit ok = 0;
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      cycles++;
      if (sd_start_read) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check({tag, "_start_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_end(input string tag);
    int snap = done_total + err_total;
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done_total + err_total != snap) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check({tag, "_end_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic feed(input int n, input logic [7:0] xr, input bit chk_lat, input bit end_blk);
    for (int i = 0; i < n; i++) begin
      sd_read_data_valid = 1'b1;
      sd_read_data = 8'(i) ^ xr;
      sd_read_done = end_blk && (i == n - 1);
      tick();
      if (chk_lat && i == 0) begin
        check("wr_latency_we", 32'(mem_we), 32'd1);
        check("wr_latency_addr", 32'(mem_addr), 32'd0);
      end
    end
    sd_read_data_valid = 1'b0;
    sd_read_done = 1'b0;
  endtask

  int s_sr, s_wr, s_dn, s_er, cyc, bad;

  task automatic snap();
    s_sr = sr_total; s_wr = wr_total; s_dn = done_total; s_er = err_total;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_block = '0; num_blocks = '0;
    sd_init_done = 1'b1; sd_read_data = '0; sd_read_data_valid = 1'b0;
    sd_read_done = 1'b0; sd_error = 1'b0;
    repeat (3) tick();
    check("reset_ctrl", {27'd0, busy, done, error, sd_start_read, mem_we}, 32'd0);
    check("reset_err_code", 32'(err_code), 32'd0);
    check("reset_blocks", 32'(blocks_loaded), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Three-sector load
    snap();
    do_start(100, 3);
    check("busy_cycle1", 32'(busy), 32'd1);
    wait_start("three_s0", cyc);
    check("start_read_cycle3", 32'(cyc), 32'd2);
    feed(512, 8'h00, 1'b1, 1'b1);
    wait_start("three_s1", cyc);
    feed(512, 8'h00, 1'b0, 1'b1);
    wait_start("three_s2", cyc);
    feed(512, 8'h00, 1'b0, 1'b1);
    wait_end("three");
    check("three_addr0", blk_addr[s_sr % 64], 32'd100);
    check("three_addr1", blk_addr[(s_sr + 1) % 64], 32'd101);
    check("three_addr2", blk_addr[(s_sr + 2) % 64], 32'd102);
    check("three_writes", 32'(wr_total - s_wr), 32'd1536);
    check("three_last_addr", 32'(last_wr_addr), 32'd1535);
    bad = 0;
    for (int k = 0; k < 1536; k++) if (rom[k] !== 8'(k)) bad++;
    check("three_rom_bad", 32'(bad), 32'd0);
    check("three_done", 32'(done_total - s_dn), 32'd1);
    check("three_blocks", 32'(blocks_loaded), 32'd3);
    check("three_busy_after", 32'(busy), 32'd0);
`ifdef SD_LOADER_CHECKSUM_EN
    check("three_checksum", 32'(checksum), 32'd64768);
`endif
    $display("txn three-sector load: blocks=%0d writes=%0d", blocks_loaded, wr_total - s_wr);

    // Short sector with retry
    tick();
    snap();
    do_start(200, 2);
    wait_start("short_s0", cyc);
    feed(512, 8'h00, 1'b0, 1'b1);
    wait_start("short_s1a", cyc);
    feed(511, 8'hFF, 1'b0, 1'b1);
    wait_start("short_s1b", cyc);
    feed(512, 8'h00, 1'b0, 1'b1);
    wait_end("short");
    check("short_pulses", 32'(sr_total - s_sr), 32'd3);
    check("short_addr1", blk_addr[(s_sr + 1) % 64], 32'd201);
    check("short_addr2", blk_addr[(s_sr + 2) % 64], 32'd201);
    check("short_rewind", 32'(first_wr[(s_sr + 2) % 64]), 32'd512);
    check("short_writes", 32'(wr_total - s_wr), 32'd1535);
    bad = 0;
    for (int k = 512; k < 1024; k++) if (rom[k] !== 8'(k)) bad++;
    check("short_rom_bad", 32'(bad), 32'd0);
    check("short_done", 32'(done_total - s_dn), 32'd1);
    check("short_no_error", 32'(err_total - s_er), 32'd0);
    $display("txn short-sector retry: pulses=%0d writes=%0d", sr_total - s_sr, wr_total - s_wr);

    // Retries exhausted
    tick();
    snap();
    sd_error = 1'b1;
    do_start(5, 2);
    wait_end("exhaust");
    sd_error = 1'b0;
    check("exhaust_pulses", 32'(sr_total - s_sr), 32'd4);
    check("exhaust_error", 32'(err_total - s_er), 32'd1);
    check("exhaust_code", 32'(err_code), 32'd2);
    check("exhaust_blocks", 32'(blocks_loaded), 32'd0);
    check("exhaust_addr3", blk_addr[(s_sr + 3) % 64], 32'd5);
    $display("txn retries exhausted: pulses=%0d err_code=%0d", sr_total - s_sr, err_code);

    // Capacity overflow
    tick();
    snap();
    do_start(0, 257);
    wait_end("cap");
    check("cap_code", 32'(err_code), 32'd3);
    check("cap_error", 32'(err_total - s_er), 32'd1);
    check("cap_no_read", 32'(sr_total - s_sr), 32'd0);
    $display("txn capacity overflow: err_code=%0d", err_code);

    // Card not initialised
    tick();
    snap();
    sd_init_done = 1'b0;
    do_start(0, 1);
    wait_end("noinit");
    sd_init_done = 1'b1;
    check("noinit_code", 32'(err_code), 32'd1);
    check("noinit_no_read", 32'(sr_total - s_sr), 32'd0);
    $display("txn not initialised: err_code=%0d", err_code);

    // Zero sectors: done at cycle 2
    tick();
    snap();
    do_start(0, 0);
    check("zero_busy_c1", 32'(busy), 32'd1);
    tick();
    check("zero_done_c2", {30'd0, done, busy}, 32'd2);
    check("zero_code_cleared", 32'(err_code), 32'd0);
    repeat (3) tick();
    check("zero_no_read", 32'(sr_total - s_sr), 32'd0);
    $display("txn zero sectors: done_count=%0d", done_total - s_dn);

    // Overrun then good retry
    tick();
    snap();
    do_start(7, 1);
    wait_start("ovr_a", cyc);
    feed(513, 8'h00, 1'b0, 1'b1);
    wait_start("ovr_b", cyc);
    feed(512, 8'h00, 1'b0, 1'b1);
    wait_end("ovr");
    check("ovr_writes", 32'(wr_total - s_wr), 32'd1024);
    check("ovr_pulses", 32'(sr_total - s_sr), 32'd2);
    check("ovr_rewind", 32'(first_wr[(s_sr + 1) % 64]), 32'd0);
    check("ovr_done", 32'(done_total - s_dn), 32'd1);
    $display("txn overrun retry: writes=%0d pulses=%0d", wr_total - s_wr, sr_total - s_sr);

    // Mid-transfer reset
    tick();
    do_start(50, 1);
    wait_start("rst", cyc);
    feed(200, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_ctrl", {26'd0, busy, done, error, sd_start_read, mem_we, 1'b0}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_blk_addr", sd_block_addr, 32'd0);
    snap();
    repeat (3) tick();
    check("rst_no_activity", 32'((sr_total - s_sr) + (wr_total - s_wr)), 32'd0);
    reset = 1'b0;
    tick();
    $display("txn mid-transfer reset: busy=%0d", busy);

    // start while busy is ignored
    snap();
    do_start(300, 2);
    wait_start("busy_s0", cyc);
    base_block = 999;
    num_blocks = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(512, 8'h00, 1'b0, 1'b1);
    wait_start("busy_s1", cyc);
    feed(512, 8'h00, 1'b0, 1'b1);
    wait_end("busy");
    repeat (5) tick();
    check("busy_addr1", blk_addr[(s_sr + 1) % 64], 32'd301);
    check("busy_pulses", 32'(sr_total - s_sr), 32'd2);
    check("busy_blocks", 32'(blocks_loaded), 32'd2);
    check("busy_done", 32'(done_total - s_dn), 32'd1);
    $display("txn start while busy: pulses=%0d blocks=%0d", sr_total - s_sr, blocks_loaded);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
